// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: FSM states, line levels,
// baud divider helper and bits per byte.
// Build option: UART_FRAME_PARITY_EN adds an even-parity bit to every byte.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        NEXT,
        DONE
    } frame_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam logic START_LVL     = 1'b0;
    localparam logic STOP_LVL      = 1'b1;

`ifdef UART_FRAME_PARITY_EN
    localparam int BITS_PER_BYTE = 11;
`else
    localparam int BITS_PER_BYTE = 10;
`endif

    // Clock cycles per serial bit (truncating division).
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, optional
// even parity, stop bit. Each bit is held for BAUD_DIV cycles.
// Build option: UART_FRAME_PARITY_EN inserts the parity bit after data bit 7.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam int                BIT_W     = $clog2(BITS_PER_BYTE);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_BYTE - 1);
    // Everything after the start bit: data, optional parity, stop.
    localparam int                SH_W      = BITS_PER_BYTE - 1;

    logic [CNT_W-1:0] baud_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [SH_W-1:0]  shreg;
    logic [SH_W-1:0]  load_word;
    logic             active;

`ifdef UART_FRAME_PARITY_EN
    assign load_word = {STOP_LVL, ^tx_byte, tx_byte};
`else
    assign load_word = {STOP_LVL, tx_byte};
`endif

    assign tx_busy = active;
    // bit_cnt reaches 0 on the stop bit, so this is its final cycle.
    assign tx_done = active && (baud_cnt == '0) && (bit_cnt == '0);

    // Baud down-counter, bit counter and shift register driving the line.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= UART_IDLE_LVL;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (!active) begin
            if (tx_start) begin
                active   <= 1'b1;
                tx       <= START_LVL;
                shreg    <= load_word;
                baud_cnt <= BAUD_LAST;
                bit_cnt  <= BIT_LAST;
            end
        end else if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
        end else if (bit_cnt == '0) begin
            active <= 1'b0;
            tx     <= UART_IDLE_LVL;
        end else begin
            tx       <= shreg[0];
            shreg    <= {STOP_LVL, shreg[SH_W-1:1]};
            bit_cnt  <= bit_cnt - 1'b1;
            baud_cnt <= BAUD_LAST;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART frame transmitter: latches a NUM_BYTES word on trans_go and
// sends it byte by byte through uart_byte_tx on a registered uart_tx line.
// Build option: UART_FRAME_PARITY_EN (even parity per byte, via uart_byte_tx).
//
// state | meaning
// IDLE  | waiting for trans_go, line high
// LOAD  | present the current byte to the byte TX with tx_start
// SEND  | byte TX shifting, wait for tx_done
// NEXT  | last byte? -> DONE, else advance byte_cnt / frame_reg
// DONE  | one-cycle frame_done, busy already low
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int NUM_BYTES = 5,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int MSB_FIRST = 0
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   trans_go,
    input  logic [8*NUM_BYTES-1:0] data,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int               BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int               FRAME_W  = 8 * NUM_BYTES;
    localparam int               CNT_W    = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    frame_state_t       state;
    frame_state_t       state_nxt;
    logic [FRAME_W-1:0] frame_reg;
    logic [CNT_W-1:0]   byte_cnt;
    logic [7:0]         cur_byte;
    logic               tx_start;
    logic               tx_line;
    logic               tx_busy;
    logic               tx_done;

    // The send end of frame_reg is fixed; NEXT shifts the following byte into it.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign cur_byte = frame_reg[FRAME_W-1 -: 8];
        end else begin : g_lsb
            assign cur_byte = frame_reg[7:0];
        end
    endgenerate

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_tx (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_byte  (cur_byte),
        .tx       (tx_line),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt  = state;
        tx_start   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (trans_go) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                // Byte TX is always idle here; the guard just avoids a lost start.
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (tx_done) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                busy = 1'b1;
                if (byte_cnt == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame capture, byte advance and counter clear.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg <= '0;
            byte_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trans_go) begin
                        frame_reg <= data;
                        byte_cnt  <= '0;
                    end
                end
                NEXT: begin
                    if (byte_cnt != LAST_IDX) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (MSB_FIRST != 0) begin
                            frame_reg <= frame_reg << 8;
                        end else begin
                            frame_reg <= frame_reg >> 8;
                        end
                    end
                end
                DONE: begin
                    byte_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered line output; async reset forces it high immediately.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx <= UART_IDLE_LVL;
        end else begin
            uart_tx <= tx_line;
        end
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Parametrised multi-byte UART frame transmitter.
- Accepts one NUM_BYTES-wide word on a single-cycle go strobe and latches it.
- Serialises the word byte by byte through an internal 8N1 UART byte transmitter onto one uart_tx line.
- Sits between sensor/packet logic and the board UART pin; successor of the fixed 40-bit/5-byte sender.

Parameters:
- NUM_BYTES, 5, bytes per frame; legal range 1..16.
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- BAUD, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (truncating), must be >= 2.
- MSB_FIRST, 0, byte order: 0 = data[7:0] sent first; 1 = data[8*NUM_BYTES-1 -: 8] sent first.

Ports:
- sys_clk  input  1  system clock; single clock domain, all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- trans_go  input  1  start strobe; sampled only in IDLE.
- data  input  8*NUM_BYTES  frame payload; captured on the accepting edge.
- uart_tx  output  1  serial line; registered; idles high.
- busy  output  1  high from the accepting edge until frame_done.
- frame_done  output  1  one-cycle pulse after the stop bit of the last byte.

Behaviour:
- Reset values: uart_tx=1, busy=0, frame_done=0, FSM=IDLE, byte counter=0, shift register=0.
- Reset asserted mid-frame: uart_tx returns high immediately (async) and the frame is discarded; no frame_done is generated.
- FSM states: IDLE, LOAD, SEND, NEXT, DONE.
- IDLE -> LOAD on trans_go=1. On that edge: data is latched into frame_reg, busy goes to 1, byte_cnt is set to 0.
- LOAD (1 cycle): the selected byte is presented to the byte TX with a tx_start pulse.
- SEND: waits for tx_done from the byte TX.
- NEXT (1 cycle): if byte_cnt == NUM_BYTES-1, go to DONE; else increment byte_cnt, shift frame_reg by 8 toward the send end, and return to LOAD.
- DONE (1 cycle): frame_done=1, busy drops at the same edge, then IDLE.
- trans_go while busy=1: ignored, not queued. Changes on data while busy: no effect.
- trans_go asserted in the DONE cycle: ignored. The earliest re-accept is the cycle after frame_done.
- Byte TX timing: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is exactly BAUD_DIV cycles.
- tx_done pulses in the last cycle of the stop bit.
- Latency: the start bit of byte 0 appears on uart_tx at the 2nd rising edge after the accepting edge.
- Inter-byte gap: exactly 2 cycles of idle-high (NEXT + LOAD) between a stop bit and the next start bit.
- Byte counter is $clog2(NUM_BYTES+1) bits wide; it never wraps, and it clears on frame completion.
- NUM_BYTES=1: LOAD -> SEND -> NEXT -> DONE; no shift occurs.

Optional Feature:
- Macro: UART_FRAME_PARITY_EN.
- Defined: the byte TX inserts an even-parity bit (XOR of the 8 data bits) between data bit 7 and the stop bit. Each byte becomes 11*BAUD_DIV cycles.
- Undefined: plain 8N1, 10*BAUD_DIV cycles per byte, and no parity logic is synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum (IDLE, LOAD, SEND, NEXT, DONE);
  - UART_IDLE_LVL=1'b1, START_LVL=1'b0, STOP_LVL=1'b1;
  - function baud_div(clk_freq, baud);
  - BITS_PER_BYTE constant (10, or 11 with parity).
- One sub-module: uart_byte_tx.
  - Ports: sys_clk, rst_n, tx_start, tx_byte[7:0], tx, tx_busy, tx_done.
  - Holds the baud counter and bit counter.
- uart_frame_tx holds the FSM, frame_reg and byte_cnt.

Test Plan:
- Test parameters for all scenarios: CLK_FREQ=1_000_000, BAUD=100_000, so BAUD_DIV=10.
- Reset idle: hold rst_n=0 for 5 cycles, then release -> uart_tx=1, busy=0, frame_done=0; no line activity for 50 cycles.
- Basic frame:
  - Stimulus: NUM_BYTES=5, MSB_FIRST=0, data=40'h55_0F_F0_A5_3C, single trans_go pulse.
  - Required: bytes 3C, A5, F0, 0F, 55 decoded LSB first; start bit at accept+2; each byte 100 cycles; 2-cycle gaps; frame_done exactly 508 cycles after the start of byte 0's start bit; busy low at the same edge.
- Byte order: MSB_FIRST=1, same data -> decoded order 55, 0F, F0, A5, 3C.
- Go while busy: pulse trans_go with data=40'hFF..FF at cycle 150 of a frame -> ignored; the original 5 bytes are sent unchanged; exactly one frame_done.
- Reset mid-frame: assert rst_n=0 during byte 2, data bit 4 -> uart_tx=1 in the same cycle (async); busy=0; no frame_done. After release, a new trans_go sends a full clean frame.
- Parity build with UART_FRAME_PARITY_EN and NUM_BYTES=1:
  - data=8'h07 -> parity bit 1; data=8'h03 -> parity bit 0.
  - Frame length 110 cycles; frame_done at the 111th cycle after the start bit begins.
